ret_stack: RTL and testbench
============================

Name: ret_stack

Overview:
- Parametrised hardware return-address stack for the CPU's call/return path.
- Stores return addresses (default 10-bit PC width) on subroutine call and supplies them on return.
- Adds occupancy tracking, full/empty flags, sticky error flags, flush, and a combinational top-of-stack view.
- Sits between the PC adder/mux logic and the PC register. Control decode drives push/pop.

Parameters:
- WIDTH, 10, entry width in bits (PC width).
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- push  input  1  store din on the stack this cycle
- pop  input  1  remove the top entry this cycle
- flush  input  1  synchronous clear of stack contents
- clr_err  input  1  synchronous clear of the sticky error flags
- din  input  WIDTH  address to push
- top  output  WIDTH  current top entry (combinational); 0 when empty
- count  output  AW+1  number of valid entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky: a push was attempted while full
- underflow  output  1  sticky: a pop was attempted while empty

Behaviour:
- Reset (asynchronous, active-high): ptr=0, count=0, overflow=0, underflow=0. Therefore empty=1, full=0, top=0. Memory contents are not reset.
- Storage: circular array mem[0..DEPTH-1] with a write pointer ptr (AW bits, wraps modulo DEPTH).
  - top = mem[ptr-1] when count != 0, otherwise 0.
  - top changes in the cycle after an update; there is no added read latency.
- Priority, highest first: reset > flush > push/pop.
- flush=1: ptr=0, count=0 on the next edge. push/pop in the same cycle are ignored. Error flags are unaffected.
- clr_err=1: clears overflow and underflow. A new error in the same cycle wins, so the flag stays 1.
- push only, not full: mem[ptr]<=din, ptr+1, count+1.
- push only, full: no state change, overflow<=1 (see Optional Feature).
- pop only, not empty: ptr-1, count-1. The popped value is the top value presented in the cycle of the pop.
- pop only, empty: no state change, underflow<=1.
- push and pop together, not empty: replace the top entry. mem[ptr-1]<=din; ptr and count unchanged. No error, including when full.
- push and pop together, empty: underflow<=1, then the push proceeds. mem[0]<=din, ptr=1, count=1.
- Wrap-around: ptr arithmetic is modulo DEPTH. count saturates at DEPTH and never exceeds it, and never goes below 0.
- Reset asserted mid-operation: the state clears immediately, regardless of the clock.

Optional Feature:
- Macro: RET_STACK_CIRC_EN.
- Defined:
  - A push-only when full writes mem[ptr]<=din and advances ptr, overwriting the oldest entry.
  - count stays at DEPTH and overflow<=1.
  - top becomes din.
  - This gives the most-recent-DEPTH semantics used for deep recursion.
- Not defined: a push when full is dropped, as described in Behaviour.

Test Plan:
- Reset, then push 0x005, 0x00A, 0x00F on consecutive cycles -> count=3, top=0x00F; three pops give top 0x00A, 0x005, then 0 with empty=1.
- DEPTH=8: push values 1..8 -> full=1. Push 0x3FF -> without RET_STACK_CIRC_EN: count=8, top=8, overflow=1. With it: top=0x3FF, count=8, overflow=1, and 8 pops return 0x3FF, 8, 7, 6, 5, 4, 3, 2.
- Empty stack, pop -> underflow=1, count=0, top=0. Pulse clr_err -> underflow=0. Pop and clr_err in the same cycle -> underflow stays 1.
- Stack holding 0x011, 0x022: assert push and pop together with din=0x033 -> count=2, top=0x033; one pop -> top=0x011.
- Stack holding 4 entries: flush together with push of 0x100 -> count=0, empty=1, top=0, error flags unchanged.
- Stack holding 3 entries, then reset asserted between clock edges -> count=0, empty=1, top=0, overflow=underflow=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ret_stack.sv
// Return-address stack: circular storage with occupancy, full/empty, sticky errors and flush.
// Define RET_STACK_CIRC_EN to let a push-while-full overwrite the oldest entry.
module ret_stack #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // DEPTH is a power of two, so the full count is a lone MSB
  localparam logic [AW:0] LP_FULL = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;
  logic [AW:0]      r_count;
  logic             r_ovf;
  logic             r_unf;

  logic [AW-1:0]    w_ptr_m1;
  logic [AW-1:0]    w_ptr_n;
  logic [AW:0]      w_cnt_n;
  logic [AW-1:0]    w_waddr;
  logic             w_we;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic             w_empty;
  logic             w_full;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == LP_FULL);
  assign w_ptr_m1 = r_ptr - 1'b1;

  always_comb begin
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_count;
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    w_ovf_evt = 1'b0;
    w_unf_evt = 1'b0;
    if (flush) begin
      w_ptr_n = '0;
      w_cnt_n = '0;
    end else if (push && pop) begin
      w_we = 1'b1;
      if (w_empty) begin
        // Pop from empty is flagged, then the push lands at the base
        w_unf_evt  = 1'b1;
        w_waddr    = '0;
        w_ptr_n    = '0;
        w_ptr_n[0] = 1'b1;
        w_cnt_n    = '0;
        w_cnt_n[0] = 1'b1;
      end else begin
        w_waddr = w_ptr_m1;
      end
    end else if (push) begin
      if (!w_full) begin
        w_we    = 1'b1;
        w_ptr_n = r_ptr + 1'b1;
        w_cnt_n = r_count + 1'b1;
      end else begin
        w_ovf_evt = 1'b1;
`ifdef RET_STACK_CIRC_EN
        w_we    = 1'b1;
        w_ptr_n = r_ptr + 1'b1;
`endif
      end
    end else if (pop) begin
      if (!w_empty) begin
        w_ptr_n = w_ptr_m1;
        w_cnt_n = r_count - 1'b1;
      end else begin
        w_unf_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_n;
      r_count <= w_cnt_n;
      // A fresh error in the clearing cycle keeps the flag set
      r_ovf   <= (r_ovf & ~clr_err) | w_ovf_evt;
      r_unf   <= (r_unf & ~clr_err) | w_unf_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= din;
  end

  assign top       = w_empty ? '0 : r_mem[w_ptr_m1];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_ret_stack.sv
// Self-checking bench for ret_stack (DEPTH=8, WIDTH=10); honours RET_STACK_CIRC_EN.
module tb_ret_stack;
  logic       clk = 1'b0;
  logic       reset;
  logic       push, pop, flush, clr_err;
  logic [9:0] din;
  logic [9:0] top;
  logic [3:0] count;
  logic       empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q [$];

  ret_stack #(.WIDTH(10), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(flush),
    .clr_err(clr_err), .din(din), .top(top), .count(count), .empty(empty),
    .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // One clock with the given controls; outputs are sampled 1ns after the edge
  task automatic cyc(input logic pu, input logic po, input logic fl,
                     input logic ce, input logic [9:0] d);
    push = pu; pop = po; flush = fl; clr_err = ce; din = d;
    @(posedge clk); #1;
    push = 0; pop = 0; flush = 0; clr_err = 0; din = '0;
  endtask

  task automatic do_reset();
    push = 0; pop = 0; flush = 0; clr_err = 0; din = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    total++; if (top !== 10'h000) begin bad++; $display("FAIL reset_top got=%h exp=000", top); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err got ovf=%b unf=%b exp 0/0", overflow, underflow); end
  endtask

  task automatic test_basic();
    logic [9:0] e;
    do_reset();
    cyc(1, 0, 0, 0, 10'h005);
    total++; if (top !== 10'h005) begin bad++; $display("FAIL basic_first_top got=%h exp=005", top); end
    cyc(1, 0, 0, 0, 10'h00A);
    cyc(1, 0, 0, 0, 10'h00F);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", count); end
    total++; if (top !== 10'h00F) begin bad++; $display("FAIL basic_top got=%h exp=00F", top); end
    exp_q.push_back(10'h00A); exp_q.push_back(10'h005); exp_q.push_back(10'h000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, '0);
      e = exp_q.pop_front();
      total++; if (top !== e) begin bad++; $display("FAIL basic_pop%0d got=%h exp=%h", i, top, e); end
    end
    total++; if (empty !== 1'b1 || count !== 4'd0) begin bad++; $display("FAIL basic_empty got empty=%b count=%0d exp 1/0", empty, count); end
  endtask

  task automatic test_overflow();
    logic [9:0] e;
    do_reset();
    for (int i = 1; i <= 8; i++) cyc(1, 0, 0, 0, 10'(i));
    total++; if (full !== 1'b1 || count !== 4'd8) begin bad++; $display("FAIL ovf_full got full=%b count=%0d exp 1/8", full, count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
    cyc(1, 0, 0, 0, 10'h3FF);
    total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", count); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
`ifdef RET_STACK_CIRC_EN
    total++; if (top !== 10'h3FF) begin bad++; $display("FAIL ovf_top got=%h exp=3FF", top); end
    exp_q.push_back(10'h3FF);
    for (int i = 8; i >= 2; i--) exp_q.push_back(10'(i));
`else
    total++; if (top !== 10'h008) begin bad++; $display("FAIL ovf_top got=%h exp=008", top); end
    for (int i = 8; i >= 1; i--) exp_q.push_back(10'(i));
`endif
    // Each value is compared as the top presented in the cycle it is popped
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      total++; if (top !== e) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, top, e); end
      cyc(0, 1, 0, 0, '0);
    end
    total++; if (empty !== 1'b1 || top !== 10'h000) begin bad++; $display("FAIL ovf_drain got empty=%b top=%h exp 1/000", empty, top); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL ovf_no_unf got=%b exp=0", underflow); end
  endtask

  task automatic test_underflow();
    do_reset();
    cyc(0, 1, 0, 0, '0);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_flag got=%b exp=1", underflow); end
    total++; if (count !== 4'd0 || top !== 10'h000) begin bad++; $display("FAIL unf_state got count=%0d top=%h exp 0/000", count, top); end
    cyc(0, 0, 0, 1, '0);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", underflow); end
    cyc(0, 1, 0, 1, '0);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_clr_race got=%b exp=1", underflow); end
    cyc(0, 0, 0, 1, '0);
    cyc(1, 1, 0, 0, 10'h1AB);
    total++; if (underflow !== 1'b1) begin bad++; $display("FAIL unf_pushpop_flag got=%b exp=1", underflow); end
    total++; if (count !== 4'd1 || top !== 10'h1AB) begin bad++; $display("FAIL unf_pushpop got count=%0d top=%h exp 1/1AB", count, top); end
  endtask

  task automatic test_replace();
    do_reset();
    cyc(1, 0, 0, 0, 10'h011);
    cyc(1, 0, 0, 0, 10'h022);
    cyc(1, 1, 0, 0, 10'h033);
    total++; if (count !== 4'd2 || top !== 10'h033) begin bad++; $display("FAIL repl got count=%0d top=%h exp 2/033", count, top); end
    total++; if (underflow !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL repl_err got ovf=%b unf=%b exp 0/0", overflow, underflow); end
    cyc(0, 1, 0, 0, '0);
    total++; if (top !== 10'h011) begin bad++; $display("FAIL repl_pop got=%h exp=011", top); end
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 10'(10'h040 + i));
    cyc(1, 1, 0, 0, 10'h2AA);
    total++; if (overflow !== 1'b0 || count !== 4'd8 || top !== 10'h2AA) begin bad++; $display("FAIL repl_full got ovf=%b count=%0d top=%h exp 0/8/2AA", overflow, count, top); end
  endtask

  task automatic test_flush();
    do_reset();
    cyc(0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 10'(10'h0A0 + i));
    total++; if (count !== 4'd4) begin bad++; $display("FAIL flush_pre got=%0d exp=4", count); end
    cyc(1, 0, 1, 0, 10'h100);
    total++; if (count !== 4'd0 || empty !== 1'b1 || top !== 10'h000) begin bad++; $display("FAIL flush got count=%0d empty=%b top=%h exp 0/1/000", count, empty, top); end
    total++; if (underflow !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL flush_err got ovf=%b unf=%b exp 0/1", overflow, underflow); end
    cyc(1, 0, 0, 0, 10'h055);
    total++; if (count !== 4'd1 || top !== 10'h055) begin bad++; $display("FAIL flush_after got count=%0d top=%h exp 1/055", count, top); end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 10'(10'h070 + i));
    #2 reset = 1'b1;
    #1;
    total++; if (count !== 4'd0 || empty !== 1'b1 || top !== 10'h000) begin bad++; $display("FAIL arst got count=%0d empty=%b top=%h exp 0/1/000", count, empty, top); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL arst_err got ovf=%b unf=%b exp 0/0", overflow, underflow); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0; push = 0; pop = 0; flush = 0; clr_err = 0; din = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_underflow();
    test_replace();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
